// File: rtl/instr_memory.sv
// Read-only instruction memory for the fetch stage: registered 32-bit read at pc>>2,
// preloaded with a fixed rotating hex-digit program image, zero beyond SIZE.
module instr_memory #(
  parameter int unsigned SIZE      = 64,
  parameter int unsigned WORD      = 64,
  parameter int unsigned INSTR_LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD-1:0]      pc,
  output logic [INSTR_LEN-1:0] instruction
);

  localparam int unsigned NWORDS = SIZE / 4;
  localparam int unsigned AW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned NDIGIT = 15;

  // Word i is the digit string "123456789ABCDEF" read from index (9+i) mod 15, wrapping.
  function automatic logic [INSTR_LEN-1:0] img_word(input int unsigned i);
    logic [INSTR_LEN-1:0] w;
    w = '0;
    for (int unsigned k = 0; k < INSTR_LEN / 4; k++) begin
      w = {w[INSTR_LEN-5:0], 4'(((9 + i + k) % NDIGIT) + 1)};
    end
    return w;
  endfunction

  logic [INSTR_LEN-1:0] w_mem [NWORDS];
  logic [AW-1:0]        w_idx;
  logic                 w_in_range;
  logic [INSTR_LEN-1:0] w_rd;

  always_comb begin
    for (int unsigned i = 0; i < NWORDS; i++) begin
      w_mem[i] = img_word(i);
    end
  end

  assign w_idx      = pc[AW+1:2];
  assign w_in_range = (pc < WORD'(SIZE));

  always_comb begin
    w_rd = '0;
    if (w_in_range) begin
      w_rd = w_mem[w_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction <= '0;
    end else begin
      instruction <= w_rd;
    end
  end

endmodule

// File: tb/tb_instr_memory.sv
// Directed bench for instr_memory: image contents, registered timing, addressing and async reset.
module tb_instr_memory;

  localparam int unsigned CYCLE = 10;

  logic        clk;
  logic        rst_n;
  logic [63:0] pc;
  logic [31:0] instruction;

  int unsigned n_checks;
  int unsigned n_errors;

  logic [31:0] exp_img [16];

  instr_memory #(
    .SIZE      (64),
    .WORD      (64),
    .INSTR_LEN (32)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .instruction (instruction)
  );

  initial clk = 1'b0;
  always #(CYCLE / 2) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_img = '{32'hABCDEF12, 32'hBCDEF123, 32'hCDEF1234, 32'hDEF12345,
                32'hEF123456, 32'hF1234567, 32'h12345678, 32'h23456789,
                32'h3456789A, 32'h456789AB, 32'h56789ABC, 32'h6789ABCD,
                32'h789ABCDE, 32'h89ABCDEF, 32'h9ABCDEF1, 32'hABCDEF12};

    // t=0: reset asserted
    rst_n = 1'b0;
    pc    = 64'd0;
    #1;  check("reset_value", instruction, 32'h0000_0000);
    #1;  rst_n = 1'b1;                 // t=2, first edge at 5
    #8;  check("pc0", instruction, 32'hABCDEF12);      // t=10
    pc = 64'd4;
    #10; check("pc4", instruction, 32'hBCDEF123);      // t=20

    pc = 64'd8;
    #8;  check("pc8_after_edge", instruction, 32'hCDEF1234);   // t=28
    pc = 64'd12;
    #4;  check("pc12_no_edge_hold", instruction, 32'hCDEF1234); // t=32
    pc = 64'd16;
    #4;  check("pc16_after_edge", instruction, 32'hEF123456);  // t=36

    pc = 64'd52;
    #10; check("pc52", instruction, 32'h89ABCDEF);
    pc = 64'd56;
    #10; check("pc56", instruction, 32'h9ABCDEF1);
    pc = 64'd28;
    #10; check("pc28", instruction, 32'h23456789);
    pc = 64'd60;
    #10; check("pc60_last_word", instruction, 32'hABCDEF12);

    pc = 64'd6;
    #10; check("pc6_misaligned", instruction, 32'hBCDEF123);
    pc = 64'd64;
    #10; check("pc64_out_of_range", instruction, 32'h0000_0000);
    pc = 64'hFFFF_FFFF_FFFF_FFFC;
    #10; check("pc_max_out_of_range", instruction, 32'h0000_0000);

    pc = 64'd0;
    #10; check("pre_reset_word", instruction, 32'hABCDEF12);   // t=116, next edge 125
    #2;  rst_n = 1'b0;                                          // t=118, mid-cycle
    pc = 64'd8;
    #1;  check("async_reset_clears", instruction, 32'h0000_0000);
    #20; check("reset_held_2_edges", instruction, 32'h0000_0000); // t=139
    rst_n = 1'b1;
    #2;  check("released_before_edge", instruction, 32'h0000_0000); // t=141
    #8;  check("first_fetch_after_reset", instruction, 32'hCDEF1234); // t=149

    // Full image sweep, with a varying low-order offset inside each word
    for (int i = 0; i < 16; i++) begin
      pc = 64'(i * 4 + (i % 4));
      #10;
      check($sformatf("sweep_word%0d", i), instruction, exp_img[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
